sram_like_slave: RTL and testbench
==================================

// Module: sram_like_slave
// PURPOSE
//  Responder end of the core's sram-like bus (req/wr/size/addr/wstrb/wdata -> addr_ok/data_ok/rdata).
//  Accepts requests from one core port (inst or data), drives a synchronous single-port RAM, and returns
//  responses in order. Programmable addr_ok/data_ok stall delays let the bench stress the core's handshakes.
//  One instance per core port, between the core and the block RAM.
// PARAMETERS
//  AW     12  RAM word-address width; RAM word index is addr[AW+1:2]
//  DEPTH  4   max outstanding accepted-but-unanswered requests (power of 2, >=2)
// PORTS
//  clk             in   1   clock; all state updates on rising edge
//  resetn          in   1   reset, asynchronous, active-low
//  req             in   1   request valid from core
//  wr              in   1   1=write, 0=read
//  size            in   2   0=byte,1=half,2=word (informational; wstrb governs write lanes)
//  addr            in   32  byte address
//  wstrb           in   4   write byte enables
//  wdata           in   32  write data
//  addr_ok         out  1   request accepted this cycle when req&addr_ok
//  data_ok         out  1   one response returned this cycle (core never backpressures)
//  rdata           out  32  read data with data_ok; 0 for write responses
//  cfg_addr_delay  in   4   stall cycles before addr_ok per request
//  cfg_data_delay  in   4   extra cycles a response waits at FIFO head
//  ram_en          out  1   RAM access strobe
//  ram_we          out  4   RAM byte write enables
//  ram_addr        out  AW  RAM word address
//  ram_wdata       out  32  RAM write data
//  ram_rdata       in   32  RAM read data, valid 1 cycle after ram_en
// BEHAVIOUR
//  - Reset (async, resetn=0): addr_ok=0, data_ok=0, rdata=0, ram_en=0, ram_we=0; outstanding count, delay
//    counters, FIFO pointers cleared; in-flight requests dropped, no response ever issued for them.
//  - Accept: hs = req & addr_ok. addr_ok = (outstanding < DEPTH) & (addr_wait == cfg_addr_delay).
//    addr_wait counts up while req & !hs (saturating at cfg_addr_delay), clears to 0 on hs and while !req.
//    cfg_addr_delay=0 -> addr_ok combinationally available whenever not full.
//  - RAM issue: same cycle as hs, combinationally: ram_en=1, ram_addr=addr[AW+1:2],
//    ram_we = wr ? wstrb : 0, ram_wdata=wdata. No RAM access on any other cycle.
//  - Capture: cycle T+1 after hs, a response entry {rdata = wr ? 0 : ram_rdata} is written into the
//    response FIFO (1-cycle pending stage holds the wr flag). Entry visible at FIFO head from T+2.
//  - Return: head_age counts cycles the current head has been valid; data_ok = head_valid &
//    (head_age >= cfg_data_delay); rdata = head data while data_ok, else 0. Pop on data_ok; head_age
//    clears on pop. Minimum latency hs@T -> data_ok@T+2 (cfg_data_delay=0). Back-to-back: 1 resp/cycle.
//  - Ordering: strictly in acceptance order; reads and writes share one FIFO.
//  - Outstanding: +1 on hs, -1 on data_ok, unchanged when both same cycle; counts pending stage + FIFO.
//    Full (== DEPTH): addr_ok=0 regardless of addr_wait; pop and accept in same cycle at full is not
//    possible (addr_ok already low); accept resumes the cycle after the pop.
//  - Read-after-write same word, back-to-back: RAM write at T, read at T+1 returns new data (RAM is
//    write-first on sequential cycles by construction).
//  - cfg_* may change any time; new value applies from next comparison, never drops or duplicates entries.
//  - FIFO pointers wrap modulo DEPTH; empty when count==0, full when count==DEPTH (explicit counter).
// STRUCTURE
//  - Shared package cpu_bus_pkg: SIZE_BYTE/HALF/WORD constants, 32-bit data/addr widths.
//  - One sub-module: resp_fifo (sync FIFO, width 32, depth DEPTH, push/pop/full/empty/count,
//    async active-low reset). Top holds accept logic, delay counters, pending stage.
// TESTING
//  - Reset mid-stream: 3 reads accepted, resetn low 1 cycle -> data_ok never asserts for them, addr_ok=0
//    during reset, outstanding=0 after.
//  - Write 0x1000 wstrb=4'b0011 wdata=0xAABBCCDD over 0x11223344, read 0x1000 -> rdata=0x1122CCDD,
//    write response data_ok with rdata=0.
//  - Delays 0/0: 8 back-to-back reads -> addr_ok every cycle, first data_ok 2 cycles after first hs,
//    then one data_ok per cycle in order.
//  - cfg_addr_delay=3, cfg_data_delay=2: single read hs at req-rise+3, data_ok at hs+4.
//  - Full: DEPTH=4, cfg_data_delay=15, 6 reqs held -> exactly 4 accepted, addr_ok low until first pop,
//    5th accepted cycle after pop; all 6 responses in order.
//  - Simultaneous hs and data_ok for 20 cycles -> outstanding constant, no lost or duplicated response.

Source files
------------

// File: rtl/cpu_bus_pkg.sv
// Shared definitions for the core's sram-like bus: widths, size encodings, word types.
package cpu_bus_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] addr_t;

endpackage

// File: rtl/resp_fifo.sv
// Synchronous response FIFO; explicit occupancy counter distinguishes full from empty.
module resp_fifo
  import cpu_bus_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  word_t         data_i,
  input  logic          pop_i,
  output word_t         data_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  word_t         mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= data_i;
  end

  always_comb begin
    count_d = count_q;
    unique case ({push_i, pop_i})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_d;
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/sram_like_slave.sv
// Responder for the core's sram-like bus: accepts requests, drives a block RAM and
// returns in-order responses with programmable address/data handshake stalls.
module sram_like_slave
  import cpu_bus_pkg::*;
#(
  parameter int AW    = 12,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          req,
  input  logic          wr,
  input  logic [1:0]    size,
  input  addr_t         addr,
  input  logic [3:0]    wstrb,
  input  word_t         wdata,
  output logic          addr_ok,
  output logic          data_ok,
  output word_t         rdata,
  input  logic [3:0]    cfg_addr_delay,
  input  logic [3:0]    cfg_data_delay,
  output logic          ram_en,
  output logic [3:0]    ram_we,
  output logic [AW-1:0] ram_addr,
  output word_t         ram_wdata,
  input  word_t         ram_rdata
);

  localparam int CW = $clog2(DEPTH + 1);

  logic          hs, full, head_valid;
  logic [3:0]    addr_wait_q, addr_wait_d;
  logic [3:0]    head_age_q, head_age_d;
  logic [CW-1:0] out_cnt_q, out_cnt_d;
  logic          pend_vld_p1_q, pend_wr_p1_q;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  word_t         fifo_head, push_data;

  // Accept and RAM issue happen combinationally in the handshake cycle.
  assign full      = (out_cnt_q == CW'(DEPTH));
  assign addr_ok   = resetn & ~full & (addr_wait_q == cfg_addr_delay);
  assign hs        = req & addr_ok;
  assign ram_en    = hs;
  assign ram_we    = (hs & wr) ? wstrb : 4'b0000;
  assign ram_addr  = addr[AW+1:2];
  assign ram_wdata = wdata;

  always_comb begin
    addr_wait_d = addr_wait_q;
    if (!req || hs)                        addr_wait_d = '0;
    else if (addr_wait_q >= cfg_addr_delay) addr_wait_d = cfg_addr_delay;
    else                                   addr_wait_d = addr_wait_q + 4'd1;
  end

  // Stage p1: RAM read data is valid; writes answer with zero.
  assign push_data = pend_wr_p1_q ? '0 : ram_rdata;

  always_ff @(posedge clk) begin
    pend_wr_p1_q <= wr;
  end

  resp_fifo #(.DEPTH(DEPTH), .CW(CW)) u_resp_fifo (
    .clk_i   (clk),
    .rst_ni  (resetn),
    .push_i  (pend_vld_p1_q),
    .data_i  (push_data),
    .pop_i   (data_ok),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Stage p2: response waits at the FIFO head for cfg_data_delay cycles.
  assign head_valid = ~fifo_empty;
  assign data_ok    = head_valid & (head_age_q >= cfg_data_delay);
  assign rdata      = data_ok ? fifo_head : '0;

  always_comb begin
    head_age_d = head_age_q;
    if (!head_valid || data_ok)  head_age_d = '0;
    else if (head_age_q != 4'hF) head_age_d = head_age_q + 4'd1;
  end

  // Counts the pending stage plus FIFO entries, so accept stalls before the FIFO could overflow.
  always_comb begin
    out_cnt_d = out_cnt_q;
    unique case ({hs, data_ok})
      2'b10:   out_cnt_d = out_cnt_q + CW'(1);
      2'b01:   out_cnt_d = out_cnt_q - CW'(1);
      default: out_cnt_d = out_cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      addr_wait_q   <= '0;
      head_age_q    <= '0;
      out_cnt_q     <= '0;
      pend_vld_p1_q <= 1'b0;
    end else begin
      addr_wait_q   <= addr_wait_d;
      head_age_q    <= head_age_d;
      out_cnt_q     <= out_cnt_d;
      pend_vld_p1_q <= hs;
    end
  end

  // size is informational: wstrb alone selects write lanes.
  logic unused_bits;
  assign unused_bits = ^{size, addr[ADDR_W-1:AW+2], addr[1:0], fifo_full, fifo_count};

endmodule

// File: tb/tb_sram_like_slave.sv
// Directed bench for sram_like_slave with a behavioural block RAM and response/handshake logs.
module tb_sram_like_slave;

  localparam int AW    = 12;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          resetn, req, wr;
  logic [1:0]    size;
  logic [31:0]   addr, wdata, rdata, ram_wdata, ram_rdata;
  logic [3:0]    wstrb, ram_we, cfg_addr_delay, cfg_data_delay;
  logic          addr_ok, data_ok, ram_en;
  logic [AW-1:0] ram_addr;

  always #5 clk = ~clk;

  sram_like_slave #(.AW(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn), .req(req), .wr(wr), .size(size), .addr(addr),
    .wstrb(wstrb), .wdata(wdata), .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata),
    .cfg_addr_delay(cfg_addr_delay), .cfg_data_delay(cfg_data_delay),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  // Behavioural RAM: unwritten word w reads as 0xC0DE0000 | w.
  logic [31:0] mem [0:(1<<AW)-1];
  bit          written [0:(1<<AW)-1];

  function automatic logic [31:0] dflt(input logic [AW-1:0] w);
    return 32'hC0DE0000 | {20'h0, w};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = n[b*8 +: 8];
    return r;
  endfunction

  always @(posedge clk) begin
    if (ram_en === 1'b1) begin
      ram_rdata <= written[ram_addr] ? mem[ram_addr] : dflt(ram_addr);
      if (ram_we != 4'b0000) begin
        mem[ram_addr]     <= merge(written[ram_addr] ? mem[ram_addr] : dflt(ram_addr),
                                   ram_wdata, ram_we);
        written[ram_addr] <= 1'b1;
      end
    end
  end

  int          cyc = 0;
  logic [31:0] rq[$];
  int          rcyc[$];
  int          hq[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (resetn === 1'b1) begin
      if (data_ok === 1'b1) begin
        rq.push_back(rdata);
        rcyc.push_back(cyc);
      end
      if (req === 1'b1 && addr_ok === 1'b1) hq.push_back(cyc);
    end
  end

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  int rb, hb, rise;
  logic          l_en;
  logic [3:0]    l_we;
  logic [AW-1:0] l_addr;
  logic [31:0]   l_wdata;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    assert (act === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    req = 1'b0;
    repeat (n) step();
  endtask

  // Holds the request until accepted (bounded); leaves req asserted for back-to-back use.
  task automatic do_req(input logic w, input logic [31:0] a, input logic [3:0] be,
                        input logic [31:0] d);
    bit ok;
    int n;
    req = 1'b1; wr = w; addr = a; wstrb = be; wdata = d;
    ok = 1'b0;
    n  = 0;
    while (!ok && n < 40) begin
      @(negedge clk);
      if (addr_ok === 1'b1) begin
        ok = 1'b1;
        l_en = ram_en; l_we = ram_we; l_addr = ram_addr; l_wdata = ram_wdata;
      end
      step();
      n++;
    end
    check("accepted", 32'(ok), 32'd1);
  endtask

  initial begin
    resetn = 1'b0; req = 1'b1; wr = 1'b1; size = 2'd2; addr = 32'h1000;
    wstrb = 4'hF; wdata = 32'h0; cfg_addr_delay = 4'd0; cfg_data_delay = 4'd0;
    repeat (2) step();
    @(negedge clk);
    check("rst_addr_ok", 32'(addr_ok), 32'd0);
    check("rst_data_ok", 32'(data_ok), 32'd0);
    check("rst_rdata",   rdata,        32'd0);
    check("rst_ram_en",  32'(ram_en),  32'd0);
    check("rst_ram_we",  32'(ram_we),  32'd0);
    step();
    req = 1'b0; resetn = 1'b1;
    step();

    // Partial write over a full word, then read back the merged word.
    rb = rq.size();
    do_req(1'b1, 32'h1000, 4'hF, 32'h11223344);
    do_req(1'b1, 32'h1000, 4'h3, 32'hAABBCCDD);
    check("wr_ram_en",    32'(l_en),   32'd1);
    check("wr_ram_we",    32'(l_we),   32'h3);
    check("wr_ram_addr",  32'(l_addr), 32'h400);
    check("wr_ram_wdata", l_wdata,     32'hAABBCCDD);
    do_req(1'b0, 32'h1000, 4'hF, 32'h0);
    check("rd_ram_we", 32'(l_we), 32'h0);
    idle(6);
    check("wr_rd_count", 32'(rq.size() - rb), 32'd3);
    check("wr1_rdata", rq[rb],   32'h0);
    check("wr2_rdata", rq[rb+1], 32'h0);
    check("rd_merged", rq[rb+2], 32'h1122CCDD);

    // Eight back-to-back reads with no stalls.
    rb = rq.size(); hb = hq.size();
    for (int i = 0; i < 8; i++) do_req(1'b0, 32'(32'h40 + 4*i), 4'hF, 32'h0);
    idle(6);
    check("b2b_count",    32'(rq.size() - rb),        32'd8);
    check("b2b_hs_span",  32'(hq[hb+7] - hq[hb]),     32'd7);
    check("b2b_latency",  32'(rcyc[rb] - hq[hb]),     32'd2);
    check("b2b_resp_span", 32'(rcyc[rb+7] - rcyc[rb]), 32'd7);
    for (int i = 0; i < 8; i++) check("b2b_rdata", rq[rb+i], 32'(32'hC0DE0010 + i));

    // Address stall 3, data stall 2.
    cfg_addr_delay = 4'd3; cfg_data_delay = 4'd2;
    step();
    rb = rq.size(); hb = hq.size(); rise = cyc;
    do_req(1'b0, 32'h80, 4'hF, 32'h0);
    idle(8);
    check("dly_count",   32'(rq.size() - rb),   32'd1);
    check("dly_hs",      32'(hq[hb] - rise),    32'd3);
    check("dly_data_ok", 32'(rcyc[rb] - hq[hb]), 32'd4);
    check("dly_rdata",   rq[rb],                32'hC0DE0020);

    // Fill to DEPTH with a long head stall; accept resumes the cycle after each pop.
    cfg_addr_delay = 4'd0; cfg_data_delay = 4'd15;
    rb = rq.size(); hb = hq.size();
    for (int i = 0; i < 6; i++) do_req(1'b0, 32'(32'hC0 + 4*i), 4'hF, 32'h0);
    idle(70);
    check("full_count",   32'(rq.size() - rb),     32'd6);
    check("full_first4",  32'(hq[hb+3] - hq[hb]),  32'd3);
    check("full_pop1",    32'(rcyc[rb] - hq[hb]),  32'd17);
    check("full_acc5",    32'(hq[hb+4] - hq[hb]),  32'd18);
    check("full_acc6",    32'(hq[hb+5] - hq[hb]),  32'd34);
    check("full_pop6",    32'(rcyc[rb+5] - hq[hb]), 32'd97);
    for (int i = 0; i < 6; i++) check("full_rdata", rq[rb+i], 32'(32'hC0DE0030 + i));

    // Sustained stream: accept and return in the same cycle.
    cfg_data_delay = 4'd0;
    rb = rq.size(); hb = hq.size();
    for (int i = 0; i < 24; i++) do_req(1'b0, 32'(32'h400 + 4*i), 4'hF, 32'h0);
    idle(6);
    check("sim_count",     32'(rq.size() - rb),         32'd24);
    check("sim_hs_span",   32'(hq[hb+23] - hq[hb]),     32'd23);
    check("sim_resp_span", 32'(rcyc[rb+23] - rcyc[rb]), 32'd23);
    for (int i = 0; i < 24; i++) check("sim_rdata", rq[rb+i], 32'(32'hC0DE0100 + i));

    // Reset with three reads in flight: they must vanish.
    cfg_data_delay = 4'd5;
    rb = rq.size();
    for (int i = 0; i < 3; i++) do_req(1'b0, 32'(32'h200 + 4*i), 4'hF, 32'h0);
    resetn = 1'b0; wr = 1'b0;
    @(negedge clk);
    check("mid_rst_addr_ok", 32'(addr_ok), 32'd0);
    check("mid_rst_ram_en",  32'(ram_en),  32'd0);
    step();
    resetn = 1'b1;
    idle(20);
    check("mid_rst_dropped", 32'(rq.size() - rb), 32'd0);

    // Outstanding cleared: DEPTH fresh requests accepted back to back.
    cfg_data_delay = 4'd15;
    rb = rq.size(); hb = hq.size();
    for (int i = 0; i < 4; i++) do_req(1'b0, 32'(32'h240 + 4*i), 4'hF, 32'h0);
    idle(70);
    check("post_rst_hs_span", 32'(hq[hb+3] - hq[hb]), 32'd3);
    check("post_rst_count",   32'(rq.size() - rb),    32'd4);
    check("post_rst_first",   rq[rb],                 32'hC0DE0090);
    check("post_rst_last",    rq[rb+3],               32'hC0DE0093);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
